// File: rtl/cache_req_arb.sv
// cache_req_arb: shares one cache request/response port between instruction
// fetch (port 0) and data access (port 1). Requests are granted round-robin.
// A grant stays locked while the cache stalls it. Responses are routed back
// through an in-order tag FIFO that records which port issued each request.

package cache_req_arb_pkg;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

module cache_req_arb
  import cache_req_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  mem_req_4B_t  req0_msg,
  input  logic         req1_val,
  output logic         req1_rdy,
  input  mem_req_4B_t  req1_msg,
  output logic         resp0_val,
  input  logic         resp0_rdy,
  output mem_resp_4B_t resp0_msg,
  output logic         resp1_val,
  input  logic         resp1_rdy,
  output mem_resp_4B_t resp1_msg,
  output logic         cachereq_val,
  input  logic         cachereq_rdy,
  output mem_req_4B_t  cachereq_msg,
  input  logic         cacheresp_val,
  output logic         cacheresp_rdy,
  input  mem_resp_4B_t cacheresp_msg
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(MAX_OUTSTANDING);

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW:0]                count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic                       prio_q, prio_d;
  logic                       lock_q, lock_d;
  logic                       lock_id_q, lock_id_d;

  logic win_vld;
  logic win_id;
  logic fifo_full;
  logic fifo_empty;
  logic head;
  logic push;
  logic pop;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never opens a slot for a same-cycle push.
  assign fifo_full  = (count_q == CNT_MAX);
  assign fifo_empty = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];

  // Winner selection: a locked grant holds; otherwise a lone requester wins,
  // and a tie goes to the port named by the round-robin pointer.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (lock_q) begin
      win_id  = lock_id_q;
      win_vld = lock_id_q ? req1_val : req0_val;
    end else if (req0_val && req1_val) begin
      win_vld = 1'b1;
      win_id  = prio_q;
    end else if (req0_val) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (req1_val) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end
  end

  // Request-side outputs; every val/rdy is forced low while reset is held.
  assign cachereq_val = rst & win_vld & ~fifo_full;
  assign req0_rdy     = rst & win_vld & ~win_id & ~fifo_full & cachereq_rdy;
  assign req1_rdy     = rst & win_vld &  win_id & ~fifo_full & cachereq_rdy;
  assign cachereq_msg = !win_vld ? '0 : (win_id ? req1_msg : req0_msg);

  // Response-side outputs: only the port whose tag is at the FIFO head sees
  // a valid, and the cache is back-pressured by that port's ready alone.
  assign resp0_val     = rst & cacheresp_val & ~fifo_empty & ~head;
  assign resp1_val     = rst & cacheresp_val & ~fifo_empty &  head;
  assign resp0_msg     = cacheresp_msg;
  assign resp1_msg     = cacheresp_msg;
  assign cacheresp_rdy = rst & ~fifo_empty & (head ? resp1_rdy : resp0_rdy);

  assign push = cachereq_val & cachereq_rdy;
  assign pop  = cacheresp_val & cacheresp_rdy;

  // Next-state: tag FIFO bookkeeping, round-robin pointer and grant lock.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_d     = tag_q;
    prio_d    = prio_q;
    count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    // A presented-but-stalled request pins the grant; acceptance releases it.
    lock_d    = cachereq_val & ~cachereq_rdy;
    lock_id_d = win_id;
    if (push) begin
      tag_d[wr_ptr_q] = win_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      prio_d          = ~win_id;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // State registers; asynchronous reset discards all in-flight tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_q     <= '0;
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_q     <= tag_d;
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_cache_req_arb.sv
// Testbench for cache_req_arb: directed stimulus with a scoreboard. Stimulus
// pushes expected cache requests and port responses into queues; a monitor
// pops and compares on every handshake it observes.
module tb_cache_req_arb;
  import cache_req_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_val = 1'b0, req1_val = 1'b0;
  logic         req0_rdy, req1_rdy;
  mem_req_4B_t  req0_msg = '0, req1_msg = '0;
  logic         resp0_val, resp1_val;
  logic         resp0_rdy = 1'b0, resp1_rdy = 1'b0;
  mem_resp_4B_t resp0_msg, resp1_msg;
  logic         cachereq_val;
  logic         cachereq_rdy = 1'b0;
  mem_req_4B_t  cachereq_msg;
  logic         cacheresp_val = 1'b0;
  logic         cacheresp_rdy;
  mem_resp_4B_t cacheresp_msg = '0;

  always #5 clk = ~clk;

  cache_req_arb #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy), .cachereq_msg(cachereq_msg),
    .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy), .cacheresp_msg(cacheresp_msg)
  );

  typedef struct {
    bit          port;
    logic [31:0] val;
  } exp_t;

  exp_t exp_req_q[$];
  exp_t exp_resp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit p, input logic [31:0] v);
    exp_t e;
    e.port = p;
    e.val  = v;
    return e;
  endfunction

  // Monitor: compare every request/response handshake against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (cachereq_val && cachereq_rdy) begin
        if (exp_req_q.size() == 0) check("unexpected_cachereq", 32'd1, 32'd0);
        else begin
          e = exp_req_q.pop_front();
          check("cachereq_addr", cachereq_msg.addr, e.val);
          check("grant_port", {31'b0, req1_rdy}, {31'b0, e.port});
          check("grant_onehot", {31'b0, req0_rdy ^ req1_rdy}, 32'd1);
        end
      end
      if (resp0_val && resp0_rdy) begin
        if (exp_resp_q.size() == 0) check("unexpected_resp0", 32'd1, 32'd0);
        else begin
          e = exp_resp_q.pop_front();
          check("resp0_port", 32'd0, {31'b0, e.port});
          check("resp0_data", resp0_msg.data, e.val);
        end
      end
      if (resp1_val && resp1_rdy) begin
        if (exp_resp_q.size() == 0) check("unexpected_resp1", 32'd1, 32'd0);
        else begin
          e = exp_resp_q.pop_front();
          check("resp1_port", 32'd1, {31'b0, e.port});
          check("resp1_data", resp1_msg.data, e.val);
        end
      end
    end
  end

  task automatic set_req(input bit p, input bit v, input logic [31:0] addr);
    if (p) begin req1_val = v; req1_msg.addr = addr; end
    else   begin req0_val = v; req0_msg.addr = addr; end
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input bit p, input logic [31:0] addr);
    bit ok = 1'b0;
    #1 set_req(p, 1'b1, addr);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = p ? req1_rdy : req0_rdy;
      @(posedge clk);
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    #1 set_req(p, 1'b0, addr);
  endtask

  // Present one cache response and hold it until accepted (bounded).
  task automatic respond(input logic [31:0] data);
    bit ok = 1'b0;
    #1 cacheresp_val = 1'b1;
    cacheresp_msg.data = data;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = cacheresp_rdy;
      @(posedge clk);
    end
    if (!ok) check("respond_timeout", 32'd0, 32'd1);
    #1 cacheresp_val = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_val = 1'b0; req1_val = 1'b0; cacheresp_val = 1'b0;
    exp_req_q.delete();
    exp_resp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: all handshake outputs low even with every input asserted.
    req0_val = 1'b1; req1_val = 1'b1; cacheresp_val = 1'b1;
    cachereq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #2;
    check("rst_cachereq_val", {31'b0, cachereq_val}, 32'd0);
    check("rst_req_rdy", {30'b0, req1_rdy, req0_rdy}, 32'd0);
    check("rst_resp_val", {30'b0, resp1_val, resp0_val}, 32'd0);
    check("rst_cacheresp_rdy", {31'b0, cacheresp_rdy}, 32'd0);
    do_reset();

    // Single port-0 read reaches the cache in the same cycle; response routes to port 0.
    #1 set_req(1'b0, 1'b1, 32'h100);
    exp_req_q.push_back(mk(1'b0, 32'h100));
    #1;
    check("t1_cachereq_val", {31'b0, cachereq_val}, 32'd1);
    check("t1_req0_rdy", {31'b0, req0_rdy}, 32'd1);
    check("t1_addr", cachereq_msg.addr, 32'h100);
    @(posedge clk);
    #1 req0_val = 1'b0;
    exp_resp_q.push_back(mk(1'b0, 32'hDEADBEEF));
    cacheresp_val = 1'b1; cacheresp_msg.data = 32'hDEADBEEF;
    #1;
    check("t1_resp0_val", {31'b0, resp0_val}, 32'd1);
    check("t1_resp1_val", {31'b0, resp1_val}, 32'd0);
    @(posedge clk);
    #1 cacheresp_val = 1'b0;

    // Both ports requesting continuously alternate 0,1,0,1 from a fresh reset.
    do_reset();
    exp_req_q.push_back(mk(1'b0, 32'h0));
    exp_req_q.push_back(mk(1'b1, 32'h400));
    exp_req_q.push_back(mk(1'b0, 32'h0));
    exp_req_q.push_back(mk(1'b1, 32'h400));
    fork
      begin send(1'b0, 32'h0); send(1'b0, 32'h0); end
      begin send(1'b1, 32'h400); send(1'b1, 32'h400); end
    join
    exp_resp_q.push_back(mk(1'b0, 32'hD0));
    exp_resp_q.push_back(mk(1'b1, 32'hD1));
    exp_resp_q.push_back(mk(1'b0, 32'hD2));
    exp_resp_q.push_back(mk(1'b1, 32'hD3));
    respond(32'hD0); respond(32'hD1); respond(32'hD2); respond(32'hD3);

    // Stalled port-1 grant stays locked even though the pointer now favours port 0.
    #1 cachereq_rdy = 1'b0;
    set_req(1'b1, 1'b1, 32'h404);
    @(negedge clk);
    check("t3_val_stall", {31'b0, cachereq_val}, 32'd1);
    check("t3_req1_rdy_stall", {31'b0, req1_rdy}, 32'd0);
    @(posedge clk);
    #1 set_req(1'b0, 1'b1, 32'h8);
    repeat (2) begin
      @(negedge clk);
      check("t3_locked_addr", cachereq_msg.addr, 32'h404);
      check("t3_req0_rdy", {31'b0, req0_rdy}, 32'd0);
      @(posedge clk);
    end
    exp_req_q.push_back(mk(1'b1, 32'h404));
    exp_req_q.push_back(mk(1'b0, 32'h8));
    #1 cachereq_rdy = 1'b1;
    @(posedge clk);
    #1 req1_val = 1'b0;
    @(posedge clk);
    #1 req0_val = 1'b0;
    exp_resp_q.push_back(mk(1'b1, 32'hE1));
    exp_resp_q.push_back(mk(1'b0, 32'hE0));
    respond(32'hE1); respond(32'hE0);

    // FIFO full: four accepted, then blocked; a pop frees a slot only the next cycle.
    do_reset();
    cachereq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req_q.push_back(mk(1'b0, 32'h10 + 32'(4 * i)));
      send(1'b0, 32'h10 + 32'(4 * i));
    end
    #1 set_req(1'b0, 1'b1, 32'h20);
    exp_req_q.push_back(mk(1'b0, 32'h20));
    repeat (2) begin
      @(negedge clk);
      check("t4_full_req0_rdy", {31'b0, req0_rdy}, 32'd0);
      check("t4_full_cachereq_val", {31'b0, cachereq_val}, 32'd0);
      @(posedge clk);
    end
    #1 cacheresp_val = 1'b1; cacheresp_msg.data = 32'hA5A5A5A5;
    exp_resp_q.push_back(mk(1'b0, 32'hA5A5A5A5));
    @(negedge clk);
    check("t4_pop_cycle_req0_rdy", {31'b0, req0_rdy}, 32'd0);
    check("t4_pop_cycle_cacheresp_rdy", {31'b0, cacheresp_rdy}, 32'd1);
    @(posedge clk);
    #1 cacheresp_val = 1'b0;
    @(negedge clk);
    check("t4_freed_req0_rdy", {31'b0, req0_rdy}, 32'd1);
    @(posedge clk);
    #1 set_req(1'b0, 1'b1, 32'h24);
    @(negedge clk);
    check("t4_refull_req0_rdy", {31'b0, req0_rdy}, 32'd0);
    @(posedge clk);
    #1 req0_val = 1'b0;

    // Port-1 response at the head blocked by resp1_rdy=0; port-0 responses wait behind it.
    do_reset();
    cachereq_rdy = 1'b1;
    exp_req_q.push_back(mk(1'b1, 32'h500));
    exp_req_q.push_back(mk(1'b0, 32'h504));
    exp_req_q.push_back(mk(1'b0, 32'h508));
    send(1'b1, 32'h500); send(1'b0, 32'h504); send(1'b0, 32'h508);
    #1 resp1_rdy = 1'b0; resp0_rdy = 1'b1;
    cacheresp_val = 1'b1; cacheresp_msg.data = 32'h11111111;
    repeat (2) begin
      @(negedge clk);
      check("t5_cacheresp_rdy", {31'b0, cacheresp_rdy}, 32'd0);
      check("t5_resp1_val", {31'b0, resp1_val}, 32'd1);
      check("t5_resp0_val", {31'b0, resp0_val}, 32'd0);
      @(posedge clk);
    end
    #1 resp1_rdy = 1'b1;
    exp_resp_q.push_back(mk(1'b1, 32'h11111111));
    @(posedge clk);
    #1 cacheresp_val = 1'b0;
    exp_resp_q.push_back(mk(1'b0, 32'h22222222));
    exp_resp_q.push_back(mk(1'b0, 32'h33333333));
    respond(32'h22222222); respond(32'h33333333);

    // Asynchronous reset mid-burst with 3 outstanding.
    exp_req_q.push_back(mk(1'b0, 32'h600));
    exp_req_q.push_back(mk(1'b1, 32'h604));
    exp_req_q.push_back(mk(1'b0, 32'h608));
    send(1'b0, 32'h600); send(1'b1, 32'h604); send(1'b0, 32'h608);
    #1 cachereq_rdy = 1'b0;
    set_req(1'b0, 1'b1, 32'h700);
    set_req(1'b1, 1'b1, 32'h800);
    cacheresp_val = 1'b1; cacheresp_msg.data = 32'h0BAD0BAD;
    #1;
    check("t6_pre_cachereq_val", {31'b0, cachereq_val}, 32'd1);
    check("t6_pre_cacheresp_rdy", {31'b0, cacheresp_rdy}, 32'd1);
    #1 rst = 1'b0;
    exp_req_q.delete();
    exp_resp_q.delete();
    #1;
    check("t6_rst_cachereq_val", {31'b0, cachereq_val}, 32'd0);
    check("t6_rst_cacheresp_rdy", {31'b0, cacheresp_rdy}, 32'd0);
    check("t6_rst_resp_val", {30'b0, resp1_val, resp0_val}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_empty_cacheresp_rdy", {31'b0, cacheresp_rdy}, 32'd0);
    check("t6_empty_resp_val", {30'b0, resp1_val, resp0_val}, 32'd0);
    check("t6_prio_port0_addr", cachereq_msg.addr, 32'h700);
    @(posedge clk);
    #1 cacheresp_val = 1'b0;
    cachereq_rdy = 1'b1;
    exp_req_q.push_back(mk(1'b0, 32'h700));
    exp_req_q.push_back(mk(1'b1, 32'h800));
    @(posedge clk);
    #1 req0_val = 1'b0;
    @(posedge clk);
    #1 req1_val = 1'b0;
    exp_resp_q.push_back(mk(1'b0, 32'h77777777));
    exp_resp_q.push_back(mk(1'b1, 32'h88888888));
    respond(32'h77777777); respond(32'h88888888);

    repeat (2) @(posedge clk);
    check("end_req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    check("end_resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
